// File: rtl/lvdc_clk_pkg.sv
// Shared definitions for the phase-timing clock blocks.
//   phase_state_t : sequencer states (IDLE / ACTIVE / GAP)
//   cnt_width()   : width of the phase/gap down-counter
//   idx_width()   : width of a phase index
package lvdc_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } phase_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The counter only ever holds PHASE_LEN-1 or GAP-1. It is kept at
    // least 1 bit wide so that PHASE_LEN=GAP=1 still elaborates.
    function automatic int cnt_width(input int plen, input int gap);
        return max2(1, $clog2(max2(plen, gap)));
    endfunction

    function automatic int idx_width(input int nphase);
        return max2(1, $clog2(nphase));
    endfunction

endpackage

// File: rtl/phase_interlock_chk.sv
// Sticky onehot0 checker for phase-clock buses.
//   clk, rst : clock, async active-high reset
//   ph_da    : early phase enables
//   ph       : phase clocks
//   err      : set (registered) when either bus has more than one bit high;
//              only reset clears it
module phase_interlock_chk #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ph_da,
    input  logic [WIDTH-1:0] ph,
    output logic             err
);

    // x & (x-1) clears the lowest set bit; anything left means >1 bit high.
    function automatic logic multi_hot(input logic [WIDTH-1:0] x);
        return |(x & (x - WIDTH'(1)));
    endfunction

    logic overlap;
    assign overlap = multi_hot(ph_da) | multi_hot(ph);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= err | overlap;
    end

endmodule

// File: rtl/lvdc_phase_gen.sv
// N-phase non-overlapping timing-clock generator.
//   SIM_CLK, SIM_RST : clock, async active-high reset
//   BOP              : inhibit; no new phase starts while high
//   MODE             : 0 = free run, 1 = single step
//   STEP             : step request, sampled only in IDLE
//   PH_DA            : early phase enables (registered from next-state decode)
//   PH               : phase clocks, PH_DA delayed one cycle
//   PHN              : ~PH delayed one further cycle
//   PH_DRV           : FANOUT copies of each PH bit, no added latency
//   PHASE_IDX        : current or next phase index
//   CYC_DONE         : one-cycle pulse when the last phase's gap ends
//   ERR              : sticky overlap fault
module lvdc_phase_gen
    import lvdc_clk_pkg::*;
#(
    parameter int NPHASE    = 4,
    parameter int FANOUT    = 8,
    parameter int PHASE_LEN = 4,
    parameter int GAP       = 1
) (
    input  logic                         SIM_CLK,
    input  logic                         SIM_RST,
    input  logic                         BOP,
    input  logic                         MODE,
    input  logic                         STEP,
    output logic [NPHASE-1:0]            PH_DA,
    output logic [NPHASE-1:0]            PH,
    output logic [NPHASE-1:0]            PHN,
    output logic [NPHASE*FANOUT-1:0]     PH_DRV,
    output logic [idx_width(NPHASE)-1:0] PHASE_IDX,
    output logic                         CYC_DONE,
    output logic                         ERR
);

    localparam int CW = cnt_width(PHASE_LEN, GAP);
    localparam int IW = idx_width(NPHASE);
    localparam logic [CW-1:0]     LEN_LD = CW'(PHASE_LEN - 1);
    localparam logic [CW-1:0]     GAP_LD = CW'(GAP - 1);
    localparam logic [IW-1:0]     LAST   = IW'(NPHASE - 1);
    localparam logic [NPHASE-1:0] ONE    = NPHASE'(1);

    if (NPHASE < 2) begin : g_bad_nphase
        $error("lvdc_phase_gen: NPHASE must be >= 2");
    end
    if (PHASE_LEN < 1) begin : g_bad_len
        $error("lvdc_phase_gen: PHASE_LEN must be >= 1");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("lvdc_phase_gen: GAP must be >= 1");
    end
    if (FANOUT < 1) begin : g_bad_fanout
        $error("lvdc_phase_gen: FANOUT must be >= 1");
    end

    phase_state_t  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx_nxt;
    logic          cyc_nxt;
    logic          start_ok;

    assign start_ok = !BOP && (!MODE || STEP);

    // The counter only decrements when non-zero, so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = PHASE_IDX;
        cyc_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = LEN_LD;
                end
            end
            ST_ACTIVE: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    idx_nxt = (PHASE_IDX == LAST) ? '0 : PHASE_IDX + IW'(1);
                    cyc_nxt = (PHASE_IDX == LAST);
                    // MODE and BOP only matter here, at a phase boundary,
                    // so a phase is never cut short.
                    if (BOP || MODE) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_ACTIVE;
                        cnt_nxt   = LEN_LD;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            PHASE_IDX <= '0;
            CYC_DONE  <= 1'b0;
            PH_DA     <= '0;
            PH        <= '0;
            PHN       <= '1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            PHASE_IDX <= idx_nxt;
            CYC_DONE  <= cyc_nxt;
            // Decoded from the next state every cycle, so PH_DA rises on the
            // same edge that enters ACTIVE and cannot hold a stale value.
            PH_DA     <= (state_nxt == ST_ACTIVE) ? (ONE << idx_nxt) : '0;
            PH        <= PH_DA;
            PHN       <= ~PH;
        end
    end

    for (genvar i = 0; i < NPHASE; i++) begin : g_fan
        assign PH_DRV[i*FANOUT +: FANOUT] = {FANOUT{PH[i]}};
    end

    phase_interlock_chk #(.WIDTH(NPHASE)) u_chk (
        .clk   (SIM_CLK),
        .rst   (SIM_RST),
        .ph_da (PH_DA),
        .ph    (PH),
        .err   (ERR)
    );

endmodule

// File: tb/tb_lvdc_phase_gen.sv
module tb_lvdc_phase_gen;

    logic clk = 1'b0;
    logic rst, bop, mode, step;
    always #5 clk = ~clk;

    // Instance A: defaults (4 phases, len 4, gap 1)
    logic [3:0]  ph_da_a, ph_a, phn_a;
    logic [31:0] drv_a;
    logic [1:0]  idx_a;
    logic        cyc_a, err_a;
    // Instance B: sweep (6 phases, len 1, gap 2), free running
    logic [5:0]  ph_da_b, ph_b, phn_b;
    logic [47:0] drv_b;
    logic [2:0]  idx_b;
    logic        cyc_b, err_b;
    logic        zero = 1'b0;

    lvdc_phase_gen dut_a (
        .SIM_CLK(clk), .SIM_RST(rst), .BOP(bop), .MODE(mode), .STEP(step),
        .PH_DA(ph_da_a), .PH(ph_a), .PHN(phn_a), .PH_DRV(drv_a),
        .PHASE_IDX(idx_a), .CYC_DONE(cyc_a), .ERR(err_a)
    );

    lvdc_phase_gen #(.NPHASE(6), .FANOUT(8), .PHASE_LEN(1), .GAP(2)) dut_b (
        .SIM_CLK(clk), .SIM_RST(rst), .BOP(zero), .MODE(zero), .STEP(zero),
        .PH_DA(ph_da_b), .PH(ph_b), .PHN(phn_b), .PH_DRV(drv_b),
        .PHASE_IDX(idx_b), .CYC_DONE(cyc_b), .ERR(err_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: position t within a phase period of PL+GAP cycles;
    // the phase is high for t < PL. Advancing past the period moves to the
    // next phase, where BOP/MODE decide whether to run on or park in idle.
    typedef struct {
        bit         idle;
        int         idx;
        int         t;
        bit         cyc;
        logic [7:0] da, ph, phn;
    } mdl_t;

    function automatic logic [7:0] mask(input int n);
        return 8'((1 << n) - 1);
    endfunction

    function automatic void mdl_reset(inout mdl_t m, input int n);
        m.idle = 1; m.idx = 0; m.t = 0; m.cyc = 0;
        m.da = '0; m.ph = '0; m.phn = mask(n);
    endfunction

    function automatic void mdl_step(inout mdl_t m, input int n, input int pl, input int gp,
                                     input logic b, input logic md, input logic st);
        m.phn = ~m.ph & mask(n);
        m.ph  = m.da;
        m.cyc = 0;
        if (m.idle) begin
            if (!b && (!md || st)) begin m.idle = 0; m.t = 0; end
        end else if (m.t == pl + gp - 1) begin
            m.cyc  = (m.idx == n - 1);
            m.idx  = (m.idx + 1) % n;
            m.t    = 0;
            m.idle = b || md;
        end else begin
            m.t++;
        end
        m.da = (!m.idle && m.t < pl) ? 8'(1 << m.idx) : 8'h00;
    endfunction

    function automatic logic [63:0] fan(input logic [7:0] p, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) r[i*8+j] = p[i];
        return r;
    endfunction

    mdl_t ma, mb;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_reset(ma, 4);
            mdl_reset(mb, 6);
        end else begin
            mdl_step(ma, 4, 4, 1, bop, mode, step);
            mdl_step(mb, 6, 1, 2, 1'b0, 1'b0, 1'b0);
        end
    end

    // Compare process: every cycle, away from the active edge.
    bit fault_on = 0;
    int cnt_b = 0, last_b = -1;
    always @(negedge clk) begin
        if (!fault_on) begin
            chk("a_ph_da", ph_da_a, ma.da[3:0]);
            chk("a_ph",    ph_a,    ma.ph[3:0]);
            chk("a_phn",   phn_a,   ma.phn[3:0]);
            chk("a_drv",   drv_a,   fan(ma.ph, 4));
            chk("a_idx",   idx_a,   ma.idx);
            chk("a_cyc",   cyc_a,   ma.cyc);
            chk("a_err",   err_a,   0);
        end
        chk("b_ph_da", ph_da_b, ma.da[7:0] & 8'h00 | mb.da[5:0]);
        chk("b_ph",    ph_b,    mb.ph[5:0]);
        chk("b_phn",   phn_b,   mb.phn[5:0]);
        chk("b_drv",   drv_b,   fan(mb.ph, 6));
        chk("b_idx",   idx_b,   mb.idx);
        chk("b_cyc",   cyc_b,   mb.cyc);
        chk("b_err",   err_b,   0);
        if (rst) begin
            last_b = -1;
        end else begin
            if (cyc_b) begin
                if (last_b >= 0) chk("b_cyc_period", cnt_b - last_b, 18);
                last_b = cnt_b;
            end
            cnt_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int da_tab[11] = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 4};
        int c_first, c_second, k, hi;

        rst = 1'b1; bop = 1'b0; mode = 1'b0; step = 1'b0;
        tick(); tick();
        chk("rst_ph_da", ph_da_a, 0);
        chk("rst_ph",    ph_a,    0);
        chk("rst_phn",   phn_a,   4'hf);
        chk("rst_idx",   idx_a,   0);
        chk("rst_cyc",   cyc_a,   0);
        chk("rst_err",   err_a,   0);
        rst = 1'b0;

        // Free run: literal timeline, then cycle marker spacing.
        c_first = -1; c_second = -1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (i < 11) chk("free_ph_da", ph_da_a, 4'(da_tab[i]));
            if (i == 0) chk("free_ph_lag0", ph_a, 0);
            if (i == 1) chk("free_ph_lag1", ph_a, 4'h1);
            if (i == 1) chk("free_phn1", phn_a, 4'hf);
            if (i == 2) chk("free_phn2", phn_a, 4'he);
            if (i == 6) chk("free_drv_ph1", drv_a[15:8], 8'hff);
            if (i == 6) chk("free_drv_ph0", drv_a[7:0], 8'h00);
            if (cyc_a) begin
                if (c_first < 0) c_first = i;
                else if (c_second < 0) c_second = i;
            end
        end
        chk("free_cyc_first", c_first, 20);
        chk("free_cyc_period", c_second - c_first, 20);

        // BOP inhibit in cycle 2 of phase 1.
        k = 0;
        while (ph_da_a != 4'b0010 && k < 40) begin tick(); k++; end
        chk("bop_wait_ph1", ph_da_a, 4'b0010);
        tick();
        bop = 1'b1;
        tick(); chk("bop_ph1_c3", ph_da_a, 4'b0010);
        tick(); chk("bop_ph1_c4", ph_da_a, 4'b0010);
        tick(); chk("bop_gap", ph_da_a, 0);
        tick(); chk("bop_idle", ph_da_a, 0); chk("bop_idle_idx", idx_a, 2);
        for (int i = 0; i < 3; i++) begin tick(); chk("bop_held", ph_da_a, 0); end
        bop = 1'b0;
        tick(); chk("bop_resume", ph_da_a, 4'b0100);

        // Random BOP toggling in free run.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) bop = ~bop;
            tick();
        end
        bop = 1'b0;

        // Async reset during phase 3 active.
        k = 0;
        while (!(idx_a == 2'd3 && ph_da_a[3]) && k < 60) begin tick(); k++; end
        chk("areset_wait_ph3", ph_da_a, 4'b1000);
        #1 rst = 1'b1;
        #1;
        chk("areset_ph_da", ph_da_a, 0);
        chk("areset_ph",    ph_a,    0);
        chk("areset_phn",   phn_a,   4'hf);
        chk("areset_idx",   idx_a,   0);
        chk("areset_cyc",   cyc_a,   0);
        tick();
        rst = 1'b0;
        tick();
        chk("areset_restart", ph_da_a, 4'b0001);
        chk("areset_restart_idx", idx_a, 0);

        // Fault injection: two PH_DA bits for one cycle.
        for (int i = 0; i < 3; i++) tick();
        fault_on = 1;
        force dut_a.PH_DA = 4'b0101;
        tick();
        release dut_a.PH_DA;
        chk("fault_err_set", err_a, 1);
        for (int i = 0; i < 5; i++) begin tick(); chk("fault_err_sticky", err_a, 1); end
        mode = 1'b1;
        #1 rst = 1'b1;
        #1 chk("fault_err_clr", err_a, 0);
        fault_on = 0;
        tick(); tick();
        rst = 1'b0;

        // Single step: phases 0,1,2 once each; STEP held in ACTIVE ignored.
        tick(); tick();
        chk("step_idle", ph_da_a, 0);
        chk("step_idx0", idx_a, 0);
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            chk("step_start", ph_da_a, 4'(1 << s));
            hi = 1;
            for (int i = 1; i < 10; i++) begin
                if (s == 1 && i == 2) step = 1'b1;
                if (s == 1 && i == 3) step = 1'b0;
                tick();
                if (ph_da_a != 0) hi++;
            end
            chk("step_len", hi, 4);
            chk("step_idx", idx_a, s + 1);
            chk("step_back_idle", ph_da_a, 0);
        end

        // Random mode / step / BOP mix.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) bop = ~bop;
            step = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lvdc_phase_gen.md
Name: lvdc_phase_gen

Overview:
- Parametrised N-phase, non-overlapping timing-clock generator. It is the successor to the fixed four-phase W/X/Y/Z driver bank.
- A counter-based sequencer replaces the cross-coupled interlock. Phase length, dead time, phase count and per-phase fanout are set by parameters.
- Adds a run/single-step mode, clean BOP inhibit (no runt pulses), a cycle marker and a sticky overlap-fault flag.
- Sits between the clock-source logic and every consumer of phase-timing signals.

Parameters:
- NPHASE, 4, number of phases; legal range >= 2.
- FANOUT, 8, copies of each phase on PH_DRV.
- PHASE_LEN, 4, SIM_CLK cycles each phase is high; legal range >= 1.
- GAP, 1, dead cycles between consecutive phases; legal range >= 1.

Ports:
- SIM_CLK  in  1  single clock.
- SIM_RST  in  1  asynchronous reset, active-high.
- BOP  in  1  inhibit. When high, no new phase starts.
- MODE  in  1  0 = free run, 1 = single step.
- STEP  in  1  single-step request, level-sampled in IDLE.
- PH_DA  out  NPHASE  early phase enables, registered from the state decode.
- PH  out  NPHASE  phase clocks; PH_DA delayed one cycle.
- PHN  out  NPHASE  ~PH, delayed one further cycle.
- PH_DRV  out  NPHASE*FANOUT  fanout copies: PH_DRV[i*FANOUT+j] = PH[i], combinational, no added latency.
- PHASE_IDX  out  $clog2(NPHASE)  index of the current or next phase.
- CYC_DONE  out  1  one-cycle pulse when the last phase's GAP ends.
- ERR  out  1  sticky overlap fault.

Behaviour:
- Reset values:
  - State = IDLE, counter = 0, PHASE_IDX = 0.
  - PH_DA = 0, PH = 0, PHN = all ones.
  - CYC_DONE = 0, ERR = 0.
- Reset mid-operation: all outputs return to reset values immediately. A truncated pulse is acceptable in this case only.
- State machine, one-hot or enum with three states: IDLE, ACTIVE, GAP.
- IDLE:
  - Exits to ACTIVE on a clock edge when BOP=0 and either MODE=0, or MODE=1 with STEP=1.
  - On entry, PH_DA[PHASE_IDX] rises at that edge and the counter loads PHASE_LEN-1.
- ACTIVE:
  - PH_DA[PHASE_IDX]=1 and the counter decrements each cycle.
  - At counter=0: go to GAP, PH_DA all 0, counter loads GAP-1.
  - PH_DA is therefore high for exactly PHASE_LEN cycles.
- GAP:
  - PH_DA all 0 and the counter decrements.
  - At counter=0: PHASE_IDX advances, wrapping from NPHASE-1 to 0.
  - If the wrapped index was NPHASE-1, CYC_DONE pulses in the same edge's cycle.
  - Next state:
    - BOP=1 or MODE=1: go to IDLE.
    - Otherwise: go to ACTIVE with the new index; PH_DA rises at the same edge.
- Phase period = PHASE_LEN+GAP; full cycle = NPHASE*(PHASE_LEN+GAP).
- BOP asserted during ACTIVE: the current phase completes its full length, then GAP, then IDLE. There is no truncation and no runt.
- BOP released: the sequence resumes at the held PHASE_IDX.
- MODE changes take effect only at the end of GAP. STEP is ignored outside IDLE. In step mode, one STEP yields exactly one phase, then IDLE.
- Non-overlap: GAP >= 1 guarantees at most one PH_DA bit and at most one PH bit high in any cycle.
- ERR:
  - Set when PH_DA or PH has more than one bit high (onehot0 violation).
  - Cleared by reset only.
- Counter width: $clog2(max(PHASE_LEN,GAP)). Arithmetic is unsigned and saturates at 0 (no underflow).
- Illegal parameter values are caught at elaboration with $error.

Decomposition:
- Shared package lvdc_clk_pkg holds the state enum (IDLE/ACTIVE/GAP) and the width-computation functions.
- One sub-module, phase_interlock_chk: onehot0 checker over PH_DA and PH that produces the sticky ERR. It is reused by later clock blocks.
- The fanout stays inline.

Test Plan (defaults NPHASE=4, PHASE_LEN=4, GAP=1):
- Free run: reset, then BOP=0, MODE=0.
  - PH_DA[0] high for 4 cycles, 1 dead cycle, then PH_DA[1], and so on.
  - PH lags PH_DA by 1 cycle; PHN = ~PH lagged by 1 cycle.
  - CYC_DONE pulses every 20 cycles.
  - PH_DRV[8..15] always equal PH[1].
- BOP inhibit: assert BOP in cycle 2 of phase 1.
  - Phase 1 still high for the full 4 cycles, GAP follows, then IDLE with PHASE_IDX=2.
  - Releasing BOP starts phase 2 at the next edge.
- Single step: MODE=1, three STEP pulses spaced 10 cycles apart.
  - Exactly phases 0, 1, 2 each appear once (4 high + 1 gap), returning to IDLE between them.
  - A STEP held during ACTIVE is ignored.
- Async reset during ACTIVE of phase 3: all outputs return to reset values without waiting for a clock edge. After release, sequencing restarts at phase 0.
- Parameter sweep NPHASE=6, PHASE_LEN=1, GAP=2: period 3 cycles per phase, CYC_DONE every 18 cycles, ERR stays 0 throughout.
- Fault injection: force two PH_DA bits high for one cycle. ERR rises and stays 1 until reset.
